// File: rtl/gpio_in_dev_io_if.sv
// rtl/gpio_in_dev_io_if.sv - GPIO input device read bus (strobe, word select, read data).
interface gpio_in_dev_io_if;
  logic        GPIOe0000000_re;
  logic [1:0]  addr;
  logic [31:0] Peripheral_out;

  modport master (output GPIOe0000000_re, output addr, input Peripheral_out);
  modport slave  (input GPIOe0000000_re, input addr, output Peripheral_out);
endinterface

// File: rtl/gpio_in_dev_io.sv
// rtl/gpio_in_dev_io.sv - switch/button input port: sync, debounce, sticky events, read-to-clear status.
// Optional level interrupt output enabled by macro GPIO_IN_IRQ_EN.
module gpio_in_dev_io #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic [3:0] btn,
`ifdef GPIO_IN_IRQ_EN
  output logic       irq,
`endif
  gpio_in_dev_io_if.slave bus
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  logic [7:0]       r_sw_m, r_sw_s, r_sw_db;
  logic [3:0]       r_btn_m, r_btn_s, r_btn_db;
  logic [15:0]      r_sw_cnt;
  logic [15:0]      r_btn_cnt [4];
  logic [3:0]       r_pend;
  logic             r_sw_chg;
  logic [CNT_W-1:0] r_press_cnt;

  logic       w_sw_upd;
  logic [3:0] w_btn_upd;
  logic [3:0] w_btn_rise;
  logic [2:0] w_rise_cnt;
  logic       w_clr;

  assign w_sw_upd = (r_sw_s != r_sw_db) && (r_sw_cnt == DB_LAST);
  assign w_clr    = bus.GPIOe0000000_re && (bus.addr == 2'd1);

  always_comb begin
    w_btn_upd  = 4'b0;
    w_rise_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_btn_upd[i] = (r_btn_s[i] != r_btn_db[i]) && (r_btn_cnt[i] == DB_LAST);
      w_rise_cnt   = w_rise_cnt + {2'b0, w_btn_upd[i] & r_btn_s[i]};
    end
    w_btn_rise = w_btn_upd & r_btn_s;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_sw_m      <= '0;
      r_sw_s      <= '0;
      r_btn_m     <= '0;
      r_btn_s     <= '0;
      r_sw_db     <= '0;
      r_btn_db    <= '0;
      r_sw_cnt    <= '0;
      for (int i = 0; i < 4; i++) r_btn_cnt[i] <= '0;
      r_pend      <= '0;
      r_sw_chg    <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_sw_m  <= sw;
      r_sw_s  <= r_sw_m;
      r_btn_m <= btn;
      r_btn_s <= r_btn_m;

      // Count only while the synchronised value disagrees with the debounced one.
      if (r_sw_s == r_sw_db) begin
        r_sw_cnt <= '0;
      end else if (w_sw_upd) begin
        r_sw_db  <= r_sw_s;
        r_sw_cnt <= '0;
      end else begin
        r_sw_cnt <= r_sw_cnt + 16'd1;
      end

      for (int i = 0; i < 4; i++) begin
        if (r_btn_s[i] == r_btn_db[i]) begin
          r_btn_cnt[i] <= '0;
        end else if (w_btn_upd[i]) begin
          r_btn_db[i]  <= r_btn_s[i];
          r_btn_cnt[i] <= '0;
        end else begin
          r_btn_cnt[i] <= r_btn_cnt[i] + 16'd1;
        end
      end

      // A set on the same edge as a status read survives the clear.
      r_pend      <= (w_clr ? 4'b0 : r_pend) | w_btn_rise;
      r_sw_chg    <= (w_clr ? 1'b0 : r_sw_chg) | w_sw_upd;
      r_press_cnt <= r_press_cnt + {{(CNT_W-3){1'b0}}, w_rise_cnt};
    end
  end

`ifdef GPIO_IN_IRQ_EN
  always_ff @(negedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= r_sw_chg | (|r_pend);
  end
`endif

  always_comb begin
    case (bus.addr)
      2'd0:    bus.Peripheral_out = {20'h0, r_btn_db, r_sw_db};
      2'd1:    bus.Peripheral_out = {27'h0, r_sw_chg, r_pend};
      2'd2:    bus.Peripheral_out = 32'(r_press_cnt);
      default: bus.Peripheral_out = 32'h5357_0001;
    endcase
  end

endmodule

// File: tb/tb_gpio_in_dev_io.sv
// tb/tb_gpio_in_dev_io.sv - directed and randomized checks of gpio_in_dev_io against a behavioural model.
module tb_gpio_in_dev_io;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw;
  logic [3:0] btn;
`ifdef GPIO_IN_IRQ_EN
  logic       irq;
`endif

  gpio_in_dev_io_if bus ();

  gpio_in_dev_io #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .btn(btn),
`ifdef GPIO_IN_IRQ_EN
    .irq(irq),
`endif
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pre_req = 0;

  // Behavioural model: raw samples delayed two edges, then a "disagreeing for DB edges" rule.
  bit [11:0]   m_hist[$];
  logic [7:0]  m_sw_db;
  logic [3:0]  m_btn_db, m_pend;
  logic        m_chg, m_irq;
  logic [15:0] m_cnt;
  int          m_sw_run;
  int          m_btn_run [4];
  int          pre_done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {20'h0, m_btn_db, m_sw_db};
      2'd1:    return {27'h0, m_chg, m_pend};
      2'd2:    return {16'h0, m_cnt};
      default: return 32'h5357_0001;
    endcase
  endfunction

  always @(posedge rst or negedge clk) begin
    if (rst) begin
      m_hist = {12'h0, 12'h0};
      m_sw_db = '0; m_btn_db = '0; m_pend = '0; m_chg = 1'b0; m_irq = 1'b0; m_cnt = '0;
      m_sw_run = 0;
      for (int i = 0; i < 4; i++) m_btn_run[i] = 0;
    end else begin
      bit [11:0] s;
      logic [3:0] rise;
      logic set_chg, clr;
      if (pre_req != pre_done) begin
        m_cnt = 16'hFFFF;
        pre_done = pre_req;
      end
      s = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back({btn, sw});
      rise = '0;
      set_chg = 1'b0;
      clr = bus.GPIOe0000000_re && (bus.addr == 2'd1);
      m_irq = m_chg || (m_pend != 0);
      if (s[7:0] == m_sw_db) m_sw_run = 0;
      else if (m_sw_run == DB - 1) begin m_sw_db = s[7:0]; m_sw_run = 0; set_chg = 1'b1; end
      else m_sw_run++;
      for (int i = 0; i < 4; i++) begin
        if (s[8+i] == m_btn_db[i]) m_btn_run[i] = 0;
        else if (m_btn_run[i] == DB - 1) begin
          m_btn_db[i] = s[8+i];
          m_btn_run[i] = 0;
          rise[i] = s[8+i];
        end else m_btn_run[i]++;
      end
      m_pend = (clr ? 4'b0 : m_pend) | rise;
      m_chg  = (clr ? 1'b0 : m_chg) | set_chg;
      m_cnt  = m_cnt + 16'($countones(rise));
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      chk("model_read", bus.Peripheral_out, m_read(bus.addr));
`ifdef GPIO_IN_IRQ_EN
      chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.GPIOe0000000_re = 1'b0;
    bus.addr = a;
    #1;
    chk(name, bus.Peripheral_out, exp);
  endtask

  task automatic status_read();
    bus.addr = 2'd1;
    bus.GPIOe0000000_re = 1'b1;
    tick();
    bus.GPIOe0000000_re = 1'b0;
  endtask

  initial begin
    sw = '0; btn = '0; bus.GPIOe0000000_re = 1'b0; bus.addr = 2'd0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    rd(2'd0, 32'h0, "reset_data");
    rd(2'd1, 32'h0, "reset_status");
    rd(2'd2, 32'h0, "reset_count");
    rd(2'd3, 32'h5357_0001, "reset_id");

    btn = 4'b0001;
    repeat (3) tick();
    btn = 4'b0000;
    repeat (10) tick();
    rd(2'd0, 32'h0, "glitch_data");
    rd(2'd1, 32'h0, "glitch_status");
    rd(2'd2, 32'h0, "glitch_count");

    btn = 4'b0010;
    repeat (6) tick();
    rd(2'd0, 32'h0000_0200, "press_data");
    rd(2'd1, 32'h0000_0002, "press_status");
    rd(2'd2, 32'h0000_0001, "press_count");
    repeat (4) tick();
    btn = 4'b0000;
    status_read();
    rd(2'd1, 32'h0, "press_cleared");
    repeat (10) tick();

    sw = 8'hA5;
    repeat (6) tick();
    rd(2'd0, 32'h0000_00A5, "sw_data");
    rd(2'd1, 32'h0000_0010, "sw_status");
    status_read();
    repeat (3) tick();
    rd(2'd1, 32'h0, "sw_cleared");

    btn = 4'b1000;
    repeat (5) tick();
    bus.addr = 2'd1;
    bus.GPIOe0000000_re = 1'b1;
    tick();
    bus.GPIOe0000000_re = 1'b0;
    rd(2'd1, 32'h0000_0008, "set_wins");
    btn = 4'b0000;
    repeat (10) tick();
    status_read();

    force dut.r_press_cnt = 16'hFFFF;
    pre_req++;
    tick();
    release dut.r_press_cnt;
    rd(2'd2, 32'h0000_FFFF, "cnt_preload");
    btn = 4'b0010;
    repeat (6) tick();
    rd(2'd2, 32'h0000_0000, "cnt_wrap");
    btn = 4'b0000;
    repeat (10) tick();

`ifdef GPIO_IN_IRQ_EN
    status_read();
    tick();
    chk("irq_idle", {31'h0, irq}, 32'h0);
    btn = 4'b0100;
    repeat (6) tick();
    rd(2'd1, 32'h0000_0004, "irq_pend");
    chk("irq_lag", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'h0, irq}, 32'h1);
    btn = 4'b0000;
    status_read();
    chk("irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("irq_clear", {31'h0, irq}, 32'h0);
    repeat (10) tick();
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) sw = 8'($urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) btn[i] = ~btn[i];
      bus.addr = 2'($urandom_range(3));
      bus.GPIOe0000000_re = ($urandom_range(7) == 0);
      if (n == 1500 || n == 2200) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_dev_io.md
Name: gpio_in_dev_io

Overview:
- Memory-mapped input peripheral; the read-side counterpart to the LED/counter-control output port on the GPIO bus.
- Samples 8 slide switches and 4 push buttons, synchronises and debounces them, and latches sticky "event pending" flags.
- The CPU polls these flags through a 32-bit read port.
- Reading the status word clears the flags it returns (read-to-clear).

Parameters:
- DB_CYCLES, 4, consecutive clk cycles an input must hold a new value before the debounced copy changes. Range 1..65535. Typical sim value 4, board value 250000 (capped at 65535 by counter width).
- CNT_W, 16, width of the total-press counter.

Ports:
- clk  input  1  system clock; all state updates on negedge clk.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  8  raw slide switches, asynchronous.
- btn  input  4  raw push buttons, asynchronous, 1 = pressed.
- GPIOe0000000_re  input  1  bus read strobe for this device.
- addr  input  2  word select within the device window.
- Peripheral_out  output  32  read data.
- irq  output  1  level interrupt; present only with the optional feature (see below).

Behaviour:
- Input synchronisers:
  - sw and btn each pass through a 2-flop synchroniser (negedge clk); the second-stage outputs are sw_s and btn_s.
  - Synchroniser flops reset to 0.
- Switch debounce:
  - One shared counter, width 16.
  - If sw_s == sw_db, the counter clears to 0.
  - Otherwise it increments. When it reaches DB_CYCLES-1 with sw_s still differing, sw_db <= sw_s and the counter clears in the same edge.
  - Any change of sw_s during counting restarts the count only if sw_s returns to sw_db; a different non-equal value keeps counting.
- Button debounce:
  - Independent 16-bit counter per button, same rule as the switches, applied per bit (btn_s[i] vs btn_db[i]).
- Events:
  - Rising edge of btn_db[i] (0->1 at an update edge) sets pend[i].
  - Any update of sw_db to a different value sets sw_chg.
  - Each btn_db rising edge increments press_cnt (CNT_W bits). press_cnt wraps 0xFFFF->0x0000.
  - Multiple buttons rising on the same edge add the number of rising bits (0..4).
- Read map:
  - Peripheral_out is combinational from addr, zero latency, and valid regardless of the strobe.
  - addr 0 DATA = {20'h0, btn_db[3:0], sw_db[7:0]}
  - addr 1 STATUS = {27'h0, sw_chg, pend[3:0]}
  - addr 2 COUNT = {(32-CNT_W)'h0, press_cnt}
  - addr 3 ID = 32'h5357_0001
- Read-to-clear:
  - At the negedge where GPIOe0000000_re=1 and addr==1, sw_chg and pend clear.
  - If a new set event for a bit occurs on the same edge, that bit ends set (set wins).
  - Reads of addr 0/2/3 have no side effect.
  - A strobe held high for N cycles at addr 1 clears on each of the N edges.
- Reset (asynchronous):
  - Synchronisers, sw_db, btn_db, all debounce counters, pend, sw_chg, press_cnt and irq go to 0.
  - Peripheral_out therefore reads DATA=0, STATUS=0, COUNT=0, ID=32'h5357_0001.
  - A reset mid-debounce discards the partial count.
- Latency: a raw change held stable is visible in DATA after 2 (synchroniser) + DB_CYCLES negedges.
  - Switches already high at reset release therefore produce sw_chg=1 once debounced.
- Glitches: a raw pulse shorter than DB_CYCLES cycles never changes the debounced value, sets no flag and does not count.

Optional Feature:
- Macro GPIO_IN_IRQ_EN.
- Defined:
  - Port irq exists and is registered: irq = |{sw_chg, pend} as of the previous negedge.
  - It deasserts the edge after a clearing STATUS read (unless set wins).
  - Reset value 0.
- Undefined:
  - Port irq and its flop are absent.
  - Software polls STATUS; all other behaviour is identical.

Test Plan:
- Reset: rst=1 then 0 with sw=0, btn=0 -> reads: addr0 32'h0, addr1 32'h0, addr2 32'h0, addr3 32'h5357_0001.
- Button press: DB_CYCLES=4, btn=4'b0010 held 10 cycles -> after 6 negedges addr0=32'h0000_0200, addr1=32'h0000_0002, addr2=1. Read addr1 -> next read returns 32'h0.
- Glitch reject: btn[0] high for 3 cycles then low -> addr0, addr1, addr2 stay 0.
- Switch change: sw=8'hA5 held -> addr0=32'h0000_00A5, addr1 bit4=1. Read addr1 clears it; sw unchanged -> stays 0.
- Set-wins collision: align a STATUS read strobe with the debounce edge of btn[3] -> addr1=32'h0000_0008 after the edge. press_cnt wrap: preload via 65536 presses (or force) -> 0xFFFF then 0x0000.
- IRQ (GPIO_IN_IRQ_EN defined): btn[2] press -> irq=1 one negedge after pend[2] sets. STATUS read -> irq=0 next edge. Macro undefined: build has no irq port.
